// File: rtl/clint_mc_pkg.sv
// Shared constants for the multi-source core-local interrupt controller:
// CSR addresses, MRET encoding, mstatus bit positions and FSM states.
package clint_mc_pkg;

    localparam int HOLD_W = 3;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_MRET = 32'h3020_0073;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        WR_MSTATUS,
        WR_MEPC,
        WR_MCAUSE,
        WR_MRET,
        ASSERT
    } state_e;

    // Index width that stays legal for a single source.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_mc_prio_enc.sv
// Lowest-index-wins priority encoder over the masked pending vector.
module clint_prio_enc
    import clint_mc_pkg::*;
#(
    parameter int NUM_SRC = 8,
    localparam int IW = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/clint_mc.sv
// Core-local interrupt controller: latches NUM_SRC lines, takes the lowest
// enabled one, writes mstatus/mepc/mcause in sequence, then redirects fetch.
module clint_mc
    import clint_mc_pkg::*;
#(
    parameter int NUM_SRC      = 8,
    parameter int XLEN         = 32,
    parameter int CAUSE_OFFSET = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  int_flag_i,
    input  logic [NUM_SRC-1:0]  int_en_i,
    input  logic [31:0]         inst_i,
    input  logic [XLEN-1:0]     inst_addr_i,
    input  logic                jump_flag_i,
    input  logic [XLEN-1:0]     jump_addr_i,
    input  logic [HOLD_W-1:0]   hold_flag_i,
    input  logic [XLEN-1:0]     csr_mstatus_i,
    input  logic [XLEN-1:0]     csr_mepc_i,
    input  logic [XLEN-1:0]     csr_mtvec_i,
    output logic                we_o,
    output logic [XLEN-1:0]     waddr_o,
    output logic [XLEN-1:0]     data_o,
    output logic                hold_flag_o,
    output logic                int_assert_o,
    output logic [XLEN-1:0]     int_addr_o,
    output logic [NUM_SRC-1:0]  int_ack_o
);

    localparam int IW = idx_w(NUM_SRC);

    state_e               state, state_n;
    logic [NUM_SRC-1:0]   pend;
    logic [IW-1:0]        idx;
    logic [XLEN-1:0]      ret_addr;
    logic                 sel_vld;
    logic [IW-1:0]        sel_idx;
    logic                 idle_ok, take, mret;
    logic [XLEN-1:0]      mst_trap, mst_ret, cause;
    logic [NUM_SRC-1:0]   ack_vec;

    clint_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req   (pend & int_en_i),
        .valid (sel_vld),
        .idx   (sel_idx)
    );

    assign idle_ok = (state == IDLE) && (hold_flag_i == '0);
    assign mret    = idle_ok && (inst_i == INST_MRET);
    assign take    = idle_ok && csr_mstatus_i[MIE_BIT] && sel_vld;
    assign cause   = {1'b1, (XLEN-1)'(CAUSE_OFFSET) + (XLEN-1)'(idx)};

    always_comb begin
        mst_trap           = csr_mstatus_i;
        mst_trap[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
        mst_trap[MIE_BIT]  = 1'b0;
        mst_ret            = csr_mstatus_i;
        mst_ret[MIE_BIT]   = csr_mstatus_i[MPIE_BIT];
        mst_ret[MPIE_BIT]  = 1'b1;
        ack_vec            = '0;
        ack_vec[idx]       = 1'b1;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (mret)      state_n = WR_MRET;
                else if (take) state_n = WR_MSTATUS;
            end
            WR_MSTATUS: state_n = WR_MEPC;
            WR_MEPC:    state_n = WR_MCAUSE;
            WR_MCAUSE:  state_n = ASSERT;
            WR_MRET:    state_n = ASSERT;
            ASSERT:     state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Ack is the registered output, so a source clears the cycle after its ack;
    // a line still high re-pends because set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            idx      <= '0;
            ret_addr <= '0;
        end else begin
            pend <= (pend & ~int_ack_o) | int_flag_i;
            if (state == IDLE && state_n == WR_MSTATUS) begin
                idx      <= sel_idx;
                ret_addr <= jump_flag_i ? jump_addr_i : inst_addr_i;
            end
        end
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            hold_flag_o  <= 1'b0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
            int_ack_o    <= '0;
        end else begin
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
            int_ack_o    <= '0;
            hold_flag_o  <= (state_n != IDLE);
            case (state_n)
                WR_MSTATUS: begin
                    we_o    <= 1'b1;
                    waddr_o <= XLEN'(CSR_MSTATUS);
                    data_o  <= mst_trap;
                end
                WR_MEPC: begin
                    we_o    <= 1'b1;
                    waddr_o <= XLEN'(CSR_MEPC);
                    data_o  <= ret_addr;
                end
                WR_MCAUSE: begin
                    we_o      <= 1'b1;
                    waddr_o   <= XLEN'(CSR_MCAUSE);
                    data_o    <= cause;
                    int_ack_o <= ack_vec;
                end
                WR_MRET: begin
                    we_o    <= 1'b1;
                    waddr_o <= XLEN'(CSR_MSTATUS);
                    data_o  <= mst_ret;
                end
                ASSERT: begin
                    int_assert_o <= 1'b1;
                    int_addr_o   <= (state == WR_MCAUSE) ? csr_mtvec_i : csr_mepc_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/clint_mc.md
# clint_mc

Parametrised multi-source core-local interrupt controller, successor to the single-flag interrupt block, sitting beside the execute stage and the CSR register file. It latches up to NUM_SRC interrupt lines and masks them with a per-source enable vector and mstatus.MIE. It selects the lowest-index pending source, then holds the pipeline while it sequentially writes mstatus, mepc and mcause. Finally it redirects fetch to mtvec, and it implements MRET (restore MIE, return to mepc).

## Interface
- NUM_SRC, 8: number of interrupt sources (1..32)
- XLEN, 32: data/address width
- CAUSE_OFFSET, 16: mcause code of source 0; source i reports CAUSE_OFFSET+i
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- int_flag_i  in  NUM_SRC  interrupt request lines, level, synchronous to clk
- int_en_i  in  NUM_SRC  per-source enable (from mie)
- inst_i  in  32  instruction in execute
- inst_addr_i  in  XLEN  address of inst_i
- jump_flag_i  in  1  execute is redirecting this cycle
- jump_addr_i  in  XLEN  redirect target
- hold_flag_i  in  `Hold_Flag_Bus  pipeline hold from ctrl; nonzero blocks new decisions
- csr_mstatus_i, csr_mepc_i, csr_mtvec_i  in  XLEN  current CSR values
- we_o  out  1  CSR write enable
- waddr_o  out  XLEN  CSR write address ({20'h0, csr})
- data_o  out  XLEN  CSR write data
- hold_flag_o  out  1  pipeline hold request
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  XLEN  redirect target, valid with int_assert_o
- int_ack_o  out  NUM_SRC  one-hot, one-cycle service acknowledge

## Operation
- Pending: pend_next = (pend & ~ack) | int_flag_i. Set wins over clear, so a level source still high re-pends. Disabled sources stay latched until enabled.
- take = IDLE & hold_flag_i==0 & mstatus[3] & |(pend & int_en_i). The selected index is the lowest set bit.
- mret = IDLE & hold_flag_i==0 & inst_i==`INST_MRET. mret has priority over take.
- FSM states: IDLE, WR_MSTATUS, WR_MEPC, WR_MCAUSE, WR_MRET, ASSERT.
- IDLE + take: capture idx. Capture ret_addr = jump_flag_i ? jump_addr_i : inst_addr_i. Go to WR_MSTATUS.
- WR_MSTATUS: write mstatus with bit7 (MPIE) = old bit3 and bit3 (MIE) = 0, other bits unchanged. Go to WR_MEPC.
- WR_MEPC: write mepc = ret_addr. Go to WR_MCAUSE.
- WR_MCAUSE: write mcause = {1'b1, (XLEN-1)'(CAUSE_OFFSET+idx)}. Assert int_ack_o[idx]. Go to ASSERT, with int_addr_o = csr_mtvec_i.
- IDLE + mret: go to WR_MRET. It writes mstatus with bit3 = old bit7 and bit7 = 1, then goes to ASSERT with int_addr_o = csr_mepc_i.
- ASSERT: int_assert_o = 1, then go to IDLE.
- we_o is 1 only in the WR_* states. Otherwise we_o, waddr_o and data_o are 0.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, pend 0, idx 0, ret_addr 0.
- Asserting rst mid-sequence aborts immediately. No partial-write completion is required.
- int_flag_i high before edge E0 sets pend at E0. take is evaluated in the cycle after E0, so the state is WR_MSTATUS after E1.
- CSR writes appear in the cycles after E1, E2 and E3 (mstatus, mepc, mcause). int_ack_o appears with the mcause write.
- int_assert_o is high in the cycle after E4. The block is back in IDLE after E5.
- Interrupt latency from pend to redirect: 4 cycles. MRET latency from decision to redirect: 2 cycles.
- hold_flag_o is high in every non-IDLE state, including ASSERT.
- csr_mtvec_i and csr_mepc_i are sampled on the transition into ASSERT. The CSR file must reflect writes by the following cycle (write-through not required).
- Back-to-back: a second pending source is considered in IDLE only if mstatus.MIE is set, so nesting requires the handler to re-enable MIE.

## Structure
- Shared defines: CSR addresses (`CSR_MSTATUS, `CSR_MEPC, `CSR_MCAUSE, `CSR_MTVEC), `INST_MRET, `Hold_Flag_Bus, mstatus bit indices (MIE=3, MPIE=7), FSM state encoding.
- Sub-module clint_prio_enc: parametrised lowest-index priority encoder (NUM_SRC in, valid + $clog2(NUM_SRC) index out), purely combinational.

## Test plan
- Reset: drive rst=0 mid-WR_MEPC → all outputs 0 and state IDLE next cycle. After release, no spurious ack.
- Single source: int_en_i=8'h04, mstatus=0x8, int_flag_i[2] pulsed 1 cycle, inst_addr_i=0x100 → writes mstatus=0x80, mepc=0x100, mcause=0x80000012. int_ack_o=8'h04. int_assert_o with int_addr_o=mtvec 4 cycles after pend.
- Priority/mask: int_flag_i=8'h0A, int_en_i=8'h08 → source 3 serviced (mcause 0x80000013) and bit1 stays pending. Enabling bit1 with MIE=1 later → source 1 serviced.
- Jump in execute: jump_flag_i=1, jump_addr_i=0x200 on the take cycle → mepc=0x200.
- Gating: mstatus.MIE=0 or hold_flag_i≠0 with pending enabled source → no writes and no assert until the condition clears.
- MRET: mstatus=0x80, mepc=0x104, inst_i=MRET → mstatus write 0x88, int_assert_o with int_addr_o=0x104 two cycles later. MRET and a pending interrupt in the same cycle → MRET wins.
